// File: rtl/fpu_div_sig_iter_pkg.sv
// Shared constants and state encoding for the FDIV significand/exponent divider.
package fpu_div_sig_iter_pkg;

  localparam int unsigned SIG_W  = 24;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned BIAS   = 127;
  localparam int unsigned N_ITER = SIG_W + 2;
  localparam int unsigned CNT_W  = $clog2(N_ITER);
  localparam int unsigned QUOT_W = SIG_W + 3;
  localparam int unsigned XEXP_W = EXP_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } div_state_e;

endpackage

// File: rtl/fpu_div_sig_step.sv
// One radix-2 restoring division step: compare, conditionally subtract, shift left.
module fpu_div_sig_step
  import fpu_div_sig_iter_pkg::*;
(
  input  logic [SIG_W:0]   rem_i,
  input  logic [SIG_W-1:0] dvs_i,
  output logic [SIG_W:0]   rem_nxt_c,
  output logic             q_bit_c
);

  logic [SIG_W:0] dvs_ext;
  logic [SIG_W:0] diff;
  logic [SIG_W:0] sel;

  // rem < 2*dvs keeps the partial remainder below 2^SIG_W, so the shifted-out MSB is always 0
  always_comb begin
    dvs_ext   = {1'b0, dvs_i};
    diff      = rem_i - dvs_ext;
    q_bit_c   = (rem_i >= dvs_ext);
    sel       = q_bit_c ? diff : rem_i;
    rem_nxt_c = sel << 1;
  end

endmodule

// File: rtl/fpu_div_sig_iter.sv
// Iterative restoring significand divider with biased exponent subtract; one quotient bit per cycle.
module fpu_div_sig_iter
  import fpu_div_sig_iter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              div_start,
  input  logic [SIG_W-1:0]  sig_a,
  input  logic [SIG_W-1:0]  sig_b,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  output logic              div_rdy,
  output logic              div_busy,
  output logic [QUOT_W-1:0] quot,
  output logic [XEXP_W-1:0] exp_q,
  output logic              div_err
);

  div_state_e          state_q, state_d;
  logic [SIG_W:0]      rem_q, rem_d;
  logic [SIG_W-1:0]    dvs_q, dvs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_ITER-2:0]   qsr_q, qsr_d;
  logic [QUOT_W-1:0]   quot_q, quot_d;
  logic [XEXP_W-1:0]   exp_q_q, exp_q_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [SIG_W:0]      rem_nxt;
  logic                q_bit;

  fpu_div_sig_step u_step (
    .rem_i     (rem_q),
    .dvs_i     (dvs_q),
    .rem_nxt_c (rem_nxt),
    .q_bit_c   (q_bit)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qsr_d   = qsr_q;
    quot_d  = quot_q;
    exp_q_d = exp_q_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (div_start) begin
          rem_d   = {1'b0, sig_a};
          dvs_d   = sig_b;
          cnt_d   = '0;
          exp_q_d = XEXP_W'(exp_a) - XEXP_W'(exp_b) + XEXP_W'(BIAS);
          err_d   = ~sig_b[SIG_W-1];
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rem_d = rem_nxt;
        qsr_d = {qsr_q[N_ITER-3:0], q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_ITER - 1)) begin
          quot_d  = err_q ? '1 : {qsr_q, q_bit, |rem_nxt};
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = div_start ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!div_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qsr_q   <= '0;
      quot_q  <= '0;
      exp_q_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qsr_q   <= qsr_d;
      quot_q  <= quot_d;
      exp_q_q <= exp_q_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign div_rdy  = rdy_q;
  assign div_busy = busy_q;
  assign quot     = quot_q;
  assign exp_q    = exp_q_q;
  assign div_err  = err_q;

endmodule

// File: tb/tb_fpu_div_sig_iter.sv
// Scoreboard bench for fpu_div_sig_iter: quotient model is floor(a*2^25/b) with remainder sticky.
module tb_fpu_div_sig_iter;

  logic        clk;
  logic        reset;
  logic        div_start;
  logic [23:0] sig_a;
  logic [23:0] sig_b;
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic        div_rdy;
  logic        div_busy;
  logic [26:0] quot;
  logic [9:0]  exp_q;
  logic        div_err;

  typedef struct {
    logic [26:0] quot;
    int          expo;
    logic        err;
    longint      acc;
  } exp_t;

  exp_t   sb[$];
  int     n_chk = 0;
  int     n_err = 0;
  longint cyc   = 0;

  fpu_div_sig_iter dut (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start),
    .sig_a     (sig_a),
    .sig_b     (sig_b),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .div_rdy   (div_rdy),
    .div_busy  (div_busy),
    .quot      (quot),
    .exp_q     (exp_q),
    .div_err   (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: every div_rdy pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset && div_rdy) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_rdy: got div_rdy=1 expected no pending op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quot", 64'(quot), 64'(e.quot));
        chk("exp_q", 64'($signed(exp_q)), 64'(e.expo));
        chk("div_err", 64'(div_err), 64'(e.err));
        chk("latency", 64'(cyc - e.acc), 64'd26);
        chk("busy_at_rdy", 64'(div_busy), 64'd0);
      end
    end
  end

  function automatic exp_t model(input logic [23:0] a, input logic [23:0] b,
                                 input logic [7:0] ea, input logic [7:0] eb);
    exp_t e;
    longint unsigned num, q, r;
    if (b[23]) begin
      num    = longint'(a) * (64'd1 << 25);
      q      = num / longint'(b);
      r      = num % longint'(b);
      e.quot = {q[25:0], (r != 0)};
    end else begin
      e.quot = '1;
    end
    e.expo = int'(ea) - int'(eb) + 127;
    e.err  = ~b[23];
    e.acc  = 0;
    return e;
  endfunction

  task automatic do_op(input logic [23:0] a, input logic [23:0] b,
                       input logic [7:0] ea, input logic [7:0] eb, input int hold);
    exp_t e;
    logic seen;
    @(negedge clk);
    sig_a = a; sig_b = b; exp_a = ea; exp_b = eb;
    div_start = 1'b1;
    e = model(a, b, ea, eb);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    chk("busy_run", 64'(div_busy), 64'd1);
    sig_a = 24'($urandom); sig_b = 24'($urandom);
    exp_a = 8'($urandom); exp_b = 8'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = div_rdy;
    end
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL rdy_timeout: got no div_rdy expected one within 40 cycles (t=%0t)", $time);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rdy_hold", 64'(div_rdy), 64'd0);
    end
    div_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; div_start = 1'b0;
    sig_a = '0; sig_b = '0; exp_a = '0; exp_b = '0;
    #1;
    chk("rst_rdy", 64'(div_rdy), 64'd0);
    chk("rst_busy", 64'(div_busy), 64'd0);
    chk("rst_quot", 64'(quot), 64'd0);
    chk("rst_exp", 64'(exp_q), 64'd0);
    chk("rst_err", 64'(div_err), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    do_op(24'h800000, 24'h800000, 8'd127, 8'd127, 0);
    do_op(24'hC00000, 24'h800000, 8'd130, 8'd120, 0);
    do_op(24'h800000, 24'hC00000, 8'd100, 8'd110, 0);
    do_op(24'hFFFFFF, 24'h800000, 8'd1,   8'd254, 0);
    do_op(24'h800001, 24'hFFFFFF, 8'd254, 8'd1,   3);
    do_op(24'hA00000, 24'h400000, 8'd50,  8'd60,  1);

    // Abort mid-RUN: outputs clear at once and the aborted op never reports
    @(negedge clk);
    sig_a = 24'hE12345; sig_b = 24'h9ABCDE; exp_a = 8'd10; exp_b = 8'd20;
    div_start = 1'b1;
    repeat (10) @(negedge clk);
    chk("busy_pre_abort", 64'(div_busy), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_rdy", 64'(div_rdy), 64'd0);
    chk("abort_busy", 64'(div_busy), 64'd0);
    chk("abort_quot", 64'(quot), 64'd0);
    chk("abort_exp", 64'(exp_q), 64'd0);
    chk("abort_err", 64'(div_err), 64'd0);
    div_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("idle_after_abort", 64'(div_busy), 64'd0);

    do_op(24'h800000, 24'hC00000, 8'd127, 8'd127, 0);

    for (int k = 0; k < 40; k++) begin
      logic [23:0] a, b;
      a = {1'b1, 23'($urandom)};
      b = {1'b1, 23'($urandom)};
      if ((k % 9) == 4) b = {1'b0, 23'($urandom) | 23'd1};
      if ((k % 7) == 3) a = 24'($urandom);
      do_op(a, b, 8'($urandom_range(1, 254)), 8'($urandom_range(1, 254)),
            int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
